// File: rtl/fp_add_sub_pkg.sv
// Shared widths and record types for the FP add/sub normalisation datapath.
package fp_add_sub_pkg;

    localparam int FP_MANT_SUM_W = 32;
    localparam int FP_LZC_W      = 5;
    localparam int FP_EXP_W      = 8;

    typedef logic [FP_LZC_W-1:0] lzc_t;

    // Contents of the stage-1 register at the default widths.
    typedef struct packed {
        logic [FP_MANT_SUM_W-1:0] mant;
        logic [FP_EXP_W-1:0]      exp;
        logic                     sign;
        lzc_t                     lzc;
        logic                     zero;
    } norm_s1_t;

    // Larger of two elaboration-time integers, used to size comparators.
    function automatic int max_int(input int a, input int b);
        if (a > b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

endpackage

// File: rtl/fp_add_sub_lzc.sv
// Recursive MSB-priority encoder. q is the index of the highest set bit;
// zero flags an all-zero input (q is then 0 and meaningless).
module fp_add_sub_lzc
    import fp_add_sub_pkg::*;
#(
    parameter int WIDTH   = FP_MANT_SUM_W,
    parameter int WIDTHAD = FP_LZC_W
) (
    input  logic [WIDTH-1:0]   data,
    output logic [WIDTHAD-1:0] q,
    output logic               zero
);

    generate
        if (WIDTH == 2) begin : g_leaf
            assign q    = data[1];
            assign zero = ~|data;
        end else begin : g_node
            localparam int HALF = WIDTH / 2;

            logic [WIDTHAD-2:0] q_hi_s;
            logic [WIDTHAD-2:0] q_lo_s;
            logic               zero_hi_s;
            logic               zero_lo_s;

            fp_add_sub_lzc #(.WIDTH(HALF), .WIDTHAD(WIDTHAD - 1)) u_hi (
                .data (data[WIDTH-1:HALF]),
                .q    (q_hi_s),
                .zero (zero_hi_s)
            );

            fp_add_sub_lzc #(.WIDTH(HALF), .WIDTHAD(WIDTHAD - 1)) u_lo (
                .data (data[HALF-1:0]),
                .q    (q_lo_s),
                .zero (zero_lo_s)
            );

            // The upper half wins whenever it holds any set bit.
            assign zero = zero_hi_s & zero_lo_s;
            assign q    = zero_hi_s ? {1'b0, q_lo_s} : {1'b1, q_hi_s};
        end
    endgenerate

endmodule

// File: rtl/fp_add_sub_normalize_pipe.sv
// Post-add normalisation: stage 1 captures the sum and its leading-zero count,
// stage 2 left-shifts by min(lzc, exp) and lowers the exponent accordingly.
// Two-entry pipeline with valid/ready backpressure; outputs are registered.
module fp_add_sub_normalize_pipe
    import fp_add_sub_pkg::*;
#(
    parameter int WIDTH     = FP_MANT_SUM_W,
    parameter int WIDTHAD   = FP_LZC_W,
    parameter int EXP_WIDTH = FP_EXP_W
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_mant,
    input  logic [EXP_WIDTH-1:0] in_exp,
    input  logic                 in_sign,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_mant,
    output logic [EXP_WIDTH-1:0] out_exp,
    output logic                 out_sign,
    output logic                 out_zero,
    output logic                 out_underflow
);

    // Compare width wide enough that neither operand wraps.
    localparam int                 CMP_W   = max_int(WIDTHAD, EXP_WIDTH) + 1;
    localparam logic [WIDTHAD-1:0] LZC_MAX = WIDTHAD'(WIDTH - 1);

    // Encoder results
    logic [WIDTHAD-1:0]   lzc_q_s;
    logic                 lzc_zero_s;
    logic [WIDTHAD-1:0]   lzc_count_s;

    // Stage 1 registers
    logic                 s1_valid_r;
    logic [WIDTH-1:0]     s1_mant_r;
    logic [EXP_WIDTH-1:0] s1_exp_r;
    logic                 s1_sign_r;
    logic [WIDTHAD-1:0]   s1_lzc_r;
    logic                 s1_zero_r;

    // Stage 2 registers (drive the outputs directly)
    logic                 s2_valid_r;
    logic [WIDTH-1:0]     s2_mant_r;
    logic [EXP_WIDTH-1:0] s2_exp_r;
    logic                 s2_sign_r;
    logic                 s2_zero_r;
    logic                 s2_underflow_r;

    // Stage 2 combinational datapath
    logic                 s2_adv_s;
    logic [CMP_W-1:0]     lzc_ext_s;
    logic [CMP_W-1:0]     exp_ext_s;
    logic                 over_s;
    logic [WIDTHAD-1:0]   shift_s;
    logic [WIDTH-1:0]     shifted_s;
    logic [EXP_WIDTH-1:0] exp_adj_s;

    fp_add_sub_lzc #(.WIDTH(WIDTH), .WIDTHAD(WIDTHAD)) u_lzc (
        .data (in_mant),
        .q    (lzc_q_s),
        .zero (lzc_zero_s)
    );

    assign lzc_count_s = LZC_MAX - lzc_q_s;

    assign s2_adv_s  = !s2_valid_r || out_ready;
    assign in_ready  = !s1_valid_r || s2_adv_s;

    assign out_valid     = s2_valid_r;
    assign out_mant      = s2_mant_r;
    assign out_exp       = s2_exp_r;
    assign out_sign      = s2_sign_r;
    assign out_zero      = s2_zero_r;
    assign out_underflow = s2_underflow_r;

    // Shift amount is clamped to the exponent so the result never goes below exp 0.
    always_comb begin
        lzc_ext_s = CMP_W'(s1_lzc_r);
        exp_ext_s = CMP_W'(s1_exp_r);
        if (lzc_ext_s > exp_ext_s) begin
            over_s  = 1'b1;
            shift_s = WIDTHAD'(exp_ext_s);
        end else begin
            over_s  = 1'b0;
            shift_s = s1_lzc_r;
        end
    end

    // Logarithmic barrel shifter, one level per shift-count bit.
    always_comb begin
        shifted_s = s1_mant_r;
        for (int i = 0; i < WIDTHAD; i++) begin
            if (shift_s[i]) begin
                shifted_s = shifted_s << (1 << i);
            end else begin
                shifted_s = shifted_s;
            end
        end
    end

    assign exp_adj_s = s1_exp_r - EXP_WIDTH'(shift_s);

    // Stage 1: capture the incoming sum together with its leading-zero count.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s1_valid_r <= 1'b0;
            s1_mant_r  <= '0;
            s1_exp_r   <= '0;
            s1_sign_r  <= 1'b0;
            s1_lzc_r   <= '0;
            s1_zero_r  <= 1'b0;
        end else if (in_ready) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_mant_r <= in_mant;
                s1_exp_r  <= in_exp;
                s1_sign_r <= in_sign;
                s1_lzc_r  <= lzc_count_s;
                s1_zero_r <= lzc_zero_s;
            end
        end
    end

    // Stage 2: register the normalised result; a held result is frozen until accepted.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            s2_valid_r     <= 1'b0;
            s2_mant_r      <= '0;
            s2_exp_r       <= '0;
            s2_sign_r      <= 1'b0;
            s2_zero_r      <= 1'b0;
            s2_underflow_r <= 1'b0;
        end else if (s2_adv_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                s2_sign_r <= s1_sign_r;
                s2_zero_r <= s1_zero_r;
                if (s1_zero_r) begin
                    s2_mant_r      <= '0;
                    s2_exp_r       <= '0;
                    s2_underflow_r <= 1'b0;
                end else begin
                    s2_mant_r      <= shifted_s;
                    s2_exp_r       <= exp_adj_s;
                    s2_underflow_r <= over_s;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_add_sub_normalize_pipe.sv
// Self-checking bench for fp_add_sub_normalize_pipe: expected results are
// queued as inputs are accepted and compared as outputs are accepted.
module tb_fp_add_sub_normalize_pipe;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_mant = 32'd0;
    logic [7:0]  in_exp = 8'd0;
    logic        in_sign = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_mant;
    logic [7:0]  out_exp;
    logic        out_sign;
    logic        out_zero;
    logic        out_underflow;

    typedef struct packed {
        logic [31:0] mant;
        logic [7:0]  exp;
        logic        sign;
        logic        zero;
        logic        uf;
    } res_t;

    res_t sb[$];
    int   checks = 0;
    int   failures = 0;

    fp_add_sub_normalize_pipe dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_mant       (in_mant),
        .in_exp        (in_exp),
        .in_sign       (in_sign),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_mant      (out_mant),
        .out_exp       (out_exp),
        .out_sign      (out_sign),
        .out_zero      (out_zero),
        .out_underflow (out_underflow)
    );

    always #5 clock = ~clock;

    // Reference normalisation: count leading zeros bit by bit, clamp to exponent.
    function automatic res_t ref_norm(input logic [31:0] m, input logic [7:0] e, input logic s);
        res_t r;
        int   lz;
        int   sh;
        logic found;
        lz = 0;
        found = 1'b0;
        for (int i = 31; i >= 0; i--) begin
            if (!found) begin
                if (m[i]) found = 1'b1;
                else lz++;
            end
        end
        r.sign = s;
        if (m == 32'd0) begin
            r.mant = 32'd0;
            r.exp  = 8'd0;
            r.zero = 1'b1;
            r.uf   = 1'b0;
        end else begin
            sh = (lz > int'(e)) ? int'(e) : lz;
            r.mant = m << sh;
            r.exp  = e - 8'(sh);
            r.zero = 1'b0;
            r.uf   = (lz > int'(e));
        end
        return r;
    endfunction

    // One clock: drive inputs, sample handshake mid-cycle, advance past the edge.
    task automatic tick(input logic v, input logic [31:0] m, input logic [7:0] e, input logic s,
                        input logic ordy, output logic in_f, output logic out_f, output res_t r);
        in_valid  = v;
        in_mant   = m;
        in_exp    = e;
        in_sign   = s;
        out_ready = ordy;
        @(negedge clock);
        in_f  = v & in_ready;
        out_f = out_valid & ordy;
        r     = {out_mant, out_exp, out_sign, out_zero, out_underflow};
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        in_valid  = 1'b1;
        in_mant   = 32'h1234_5678;
        in_exp    = 8'd50;
        out_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n  = 1'b1;
        in_valid = 1'b0;
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        checks++;
        if ({out_mant, out_exp, out_sign, out_zero, out_underflow} !== 43'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h_%h_%b%b%b exp=0", out_mant, out_exp,
                     out_sign, out_zero, out_underflow);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_directed();
        logic [31:0] mants[8] = '{32'h0000_8000, 32'h0000_0001, 32'h0000_0000, 32'h8000_0001,
                                  32'h0000_0001, 32'h0000_0010, 32'h8000_0000, 32'h0000_0003};
        logic [7:0]  exps[8]  = '{8'd100, 8'd10, 8'd77, 8'd5, 8'd200, 8'd0, 8'd0, 8'd30};
        logic        signs[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic in_f, out_f, got;
        res_t r, e;
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, mants[i], exps[i], signs[i], 1'b1, in_f, out_f, r);
            checks++;
            if (!in_f) begin
                failures++;
                $display("FAIL directed_accept case=%0d got=0 exp=1", i);
            end else begin
                sb.push_back(ref_norm(mants[i], exps[i], signs[i]));
            end
            got = 1'b0;
            for (int k = 1; k <= 4; k++) begin
                tick(1'b0, 32'd0, 8'd0, 1'b0, 1'b1, in_f, out_f, r);
                if (out_f) begin
                    got = 1'b1;
                    checks++;
                    if (k != 2) begin
                        failures++;
                        $display("FAIL directed_latency case=%0d got=%0d exp=2", i, k);
                    end
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL directed_spurious case=%0d got=%h exp=none", i, r);
                    end else begin
                        e = sb.pop_front();
                        checks++;
                        if (r !== e) begin
                            failures++;
                            $display("FAIL directed_data case=%0d got=%h exp=%h", i, r, e);
                        end
                    end
                end
            end
            checks++;
            if (!got) begin
                failures++;
                $display("FAIL directed_timeout case=%0d got=no_output exp=output", i);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic        in_f, out_f, saw_block;
        logic [31:0] m;
        logic [7:0]  ex;
        res_t        r, e, held;
        int          sent, recv;
        sent = 0;
        recv = 0;
        saw_block = 1'b0;
        held = '0;
        for (int c = 0; c < 40 && recv < 8; c++) begin
            m  = 32'h0000_0100 << sent;
            ex = 8'(20 + sent);
            tick(sent < 8, m, ex, sent[0], !(c >= 3 && c <= 6), in_f, out_f, r);
            if (sent < 8 && !in_f) saw_block = 1'b1;
            if (in_f) begin
                sb.push_back(ref_norm(m, ex, sent[0]));
                sent++;
            end
            if (c == 3) begin
                held = r;
            end else if (c > 3 && c <= 6) begin
                checks++;
                if (r !== held) begin
                    failures++;
                    $display("FAIL b2b_hold cycle=%0d got=%h exp=%h", c, r, held);
                end
            end
            if (out_f) begin
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_spurious got=%h exp=none", r);
                end else begin
                    e = sb.pop_front();
                    recv++;
                    checks++;
                    if (r !== e) begin
                        failures++;
                        $display("FAIL b2b_data idx=%0d got=%h exp=%h", recv - 1, r, e);
                    end
                end
            end
        end
        checks++;
        if (recv != 8 || sb.size() != 0) begin
            failures++;
            $display("FAIL b2b_count got=%0d exp=8", recv);
        end
        checks++;
        if (!saw_block) begin
            failures++;
            $display("FAIL b2b_in_ready_low got=0 exp=1");
        end
    endtask

    task automatic test_reset_mid_stall();
        logic in_f, out_f;
        res_t r;
        tick(1'b1, 32'h0000_0F00, 8'd40, 1'b0, 1'b0, in_f, out_f, r);
        tick(1'b1, 32'h0000_00F0, 8'd40, 1'b1, 1'b0, in_f, out_f, r);
        tick(1'b1, 32'h0000_000F, 8'd40, 1'b1, 1'b0, in_f, out_f, r);
        checks++;
        if (in_f) begin
            failures++;
            $display("FAIL stall_full_in_ready got=1 exp=0");
        end
        reset_n = 1'b0;
        tick(1'b0, 32'd0, 8'd0, 1'b0, 1'b0, in_f, out_f, r);
        reset_n = 1'b1;
        sb.delete();
        for (int k = 0; k < 3; k++) begin
            tick(1'b0, 32'd0, 8'd0, 1'b0, 1'b1, in_f, out_f, r);
            checks++;
            if (out_f) begin
                failures++;
                $display("FAIL mid_stall_flush cycle=%0d got=%h exp=none", k, r);
            end
        end
    endtask

    task automatic test_random();
        logic        in_f, out_f, v;
        logic [31:0] m;
        logic [7:0]  ex;
        logic        s;
        res_t        r, e;
        int          sent, recv, cyc;
        sent = 0;
        recv = 0;
        cyc  = 0;
        while ((sent < 10000 || recv < sent) && cyc < 40000) begin
            v = (sent < 10000) && ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 7))
                0:       m = 32'd0;
                1:       m = 32'd1 << $urandom_range(0, 31);
                default: m = $urandom >> $urandom_range(0, 31);
            endcase
            if ($urandom_range(0, 1) == 0) ex = 8'($urandom_range(0, 40));
            else                           ex = 8'($urandom_range(0, 255));
            s = 1'($urandom_range(0, 1));
            tick(v, m, ex, s, $urandom_range(0, 3) != 0, in_f, out_f, r);
            if (in_f) begin
                sb.push_back(ref_norm(m, ex, s));
                sent++;
            end
            if (out_f) begin
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL random_spurious got=%h exp=none", r);
                end else begin
                    e = sb.pop_front();
                    recv++;
                    checks++;
                    if (r !== e) begin
                        failures++;
                        $display("FAIL random_data idx=%0d got=%h exp=%h", recv - 1, r, e);
                    end
                end
            end
            cyc++;
        end
        checks++;
        if (recv != sent || sent != 10000 || sb.size() != 0) begin
            failures++;
            $display("FAIL random_count got=%0d exp=%0d sent=%0d", recv, 10000, sent);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid_stall();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
